// File: rtl/adaptive_green_scheduler.sv
// Green-time scheduler: per-road arrival counters with a two-state request unit
// that turns a road's queued-vehicle snapshot into a clamped green time.
module adaptive_green_scheduler #(
  parameter int NUM_ROADS = 4,
  parameter int CNT_W     = 8,
  parameter int TG_W      = 8,
  parameter int TG_MIN    = 10,
  parameter int TG_MAX    = 60,
  parameter int WEIGHT    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ROADS-1:0]       car_in,
  input  logic                       req_valid,
  input  logic [3:0]                 req_road,
  output logic                       req_ready,
  output logic                       tg_valid,
  output logic [TG_W-1:0]            tg_value,
  output logic [3:0]                 tg_road,
  output logic                       tg_err,
  output logic [NUM_ROADS*CNT_W-1:0] counts,
  output logic [NUM_ROADS-1:0]       sat
);

  localparam int CW = CNT_W + TG_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt     [NUM_ROADS];
  logic [CNT_W-1:0]        cnt_nxt [NUM_ROADS];
  logic [NUM_ROADS-1:0]    sat_nxt;
  logic [NUM_ROADS-1:0]    clr;
  logic                    accept;
  logic                    in_range;
  logic [CNT_W-1:0]        sel_cnt;
  logic [CNT_W-1:0]        snap_q;
  logic [3:0]              road_q;
  logic                    err_q;
  logic [CW-1:0]           green_wide;
  logic [TG_W-1:0]         green;

  assign accept   = (state == IDLE) && req_valid;
  assign in_range = {1'b0, req_road} < 5'(NUM_ROADS);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = CALC;
      CALC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE);
  end

  // Accepted road is cleared first, then this cycle's arrival is applied on top
  always_comb begin
    sel_cnt = '0;
    for (int unsigned i = 0; i < NUM_ROADS; i++) begin
      clr[i]     = accept && (req_road == 4'(i));
      cnt_nxt[i] = clr[i] ? '0 : cnt[i];
      sat_nxt[i] = clr[i] ? 1'b0 : sat[i];
      if (car_in[i] && cnt_nxt[i] != CNT_MAX) cnt_nxt[i] = cnt_nxt[i] + 1'b1;
      if (car_in[i] && cnt_nxt[i] == CNT_MAX) sat_nxt[i] = 1'b1;
      if (req_road == 4'(i)) sel_cnt = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ROADS; i++) cnt[i] <= '0;
      sat <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ROADS; i++) cnt[i] <= cnt_nxt[i];
      sat <= sat_nxt;
    end
  end

  always_comb begin
    counts = '0;
    for (int unsigned i = 0; i < NUM_ROADS; i++) counts[i*CNT_W +: CNT_W] = cnt[i];
  end

  always_comb begin
    green_wide = CW'(TG_MIN) + CW'(snap_q) * CW'(WEIGHT);
    if (err_q)                        green = TG_W'(TG_MIN);
    else if (green_wide > CW'(TG_MAX)) green = TG_W'(TG_MAX);
    else                              green = green_wide[TG_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q   <= '0;
      road_q   <= '0;
      err_q    <= 1'b0;
      tg_valid <= 1'b0;
      tg_value <= '0;
      tg_road  <= '0;
      tg_err   <= 1'b0;
    end else begin
      tg_valid <= 1'b0;
      if (accept) begin
        snap_q <= in_range ? sel_cnt : '0;
        road_q <= req_road;
        err_q  <= !in_range;
      end
      if (state == CALC) begin
        tg_valid <= 1'b1;
        tg_value <= green;
        tg_road  <= road_q;
        tg_err   <= err_q;
      end
    end
  end

endmodule
